debug_slave_sysclk_ctrl: RTL and testbench



---
 rtl/debug_slave_pkg.sv | 24 ++
 rtl/debug_strobe_sync.sv | 42 ++++
 rtl/debug_slave_sysclk_ctrl.sv | 136 +++++++++++++
 tb/tb_debug_slave_sysclk_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_slave_pkg.sv
// ---------------------------------------------------------------------------
// debug_slave_pkg
// Shared definitions for the CPU debug slave: default register widths, the
// bit in the data word that selects between the two command variants, and
// the named instruction-register encodings.
// ---------------------------------------------------------------------------
package debug_slave_pkg;

  // Default widths of the JTAG instruction and data shift registers.
  localparam int DEF_IR_W    = 2;
  localparam int DEF_DR_W    = 38;

  // Bit of the data word that selects take_action (1) or take_no_action (0).
  localparam int DEF_ACT_BIT = 35;

  // Instruction encodings.  Each one selects a command channel.
  typedef enum logic [DEF_IR_W-1:0] {
    IR_OCIMEM    = 2'd0,
    IR_TRACECTRL = 2'd1,
    IR_BREAK     = 2'd2,
    IR_TRACEMEM  = 2'd3
  } ir_t;

endpackage

// File: rtl/debug_strobe_sync.sv
// ---------------------------------------------------------------------------
// debug_strobe_sync
// Brings an asynchronous level strobe from the TCK domain into clk through a
// SYNC_STAGES-deep flop chain.  One further history flop then turns each
// rising edge of the synchronised level into a single-cycle event.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset; clears the whole chain
//   strobe in   asynchronous level from the TCK domain
//   evt    out  one-cycle pulse per rising edge of the synchronised strobe
// ---------------------------------------------------------------------------
module debug_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Synchroniser chain plus history flop.  Everything clears to 0, so a
  // strobe that is already high when reset is released still gives one event.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Rising-edge detect on the last synchroniser stage.
  always_comb begin
    evt = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

endmodule

// File: rtl/debug_slave_sysclk_ctrl.sv
// ---------------------------------------------------------------------------
// debug_slave_sysclk_ctrl
// System-clock half of the CPU debug slave.  It synchronises the update-IR
// and update-DR strobes and captures the instruction and data words.  Each
// update-DR becomes a per-channel command.  With READY_EN=1 the command is
// held until the target accepts it; with READY_EN=0 it is a single-cycle
// pulse.  An update-DR that arrives while a command is still pending is
// dropped and sets the sticky overrun flag.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   ir_in          in   JTAG instruction register (IR_W)
//   sr             in   JTAG data shift register (DR_W)
//   vs_uir         in   asynchronous update-IR level
//   vs_udr         in   asynchronous update-DR level
//   cmd_ready      in   per-channel accept from the target (NUM_CH)
//   overrun_clr    in   clears the overrun flag
//   jdo            out  captured data word (DR_W)
//   ir_q           out  captured instruction (IR_W)
//   take_action    out  command valid, action variant (NUM_CH)
//   take_no_action out  command valid, no-action variant (NUM_CH)
//   busy           out  a command is pending
//   overrun        out  sticky: an update-DR arrived while busy
//   cmd_count      out  accepted-command count, wraps at 2**CNT_W
// ---------------------------------------------------------------------------
module debug_slave_sysclk_ctrl
  import debug_slave_pkg::*;
#(
  parameter int IR_W        = DEF_IR_W,
  parameter int DR_W        = DEF_DR_W,
  parameter int ACT_BIT     = DEF_ACT_BIT,
  parameter int SYNC_STAGES = 2,
  parameter int READY_EN    = 1,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [DR_W-1:0]      sr,
  input  logic                 vs_uir,
  input  logic                 vs_udr,
  input  logic [2**IR_W-1:0]   cmd_ready,
  input  logic                 overrun_clr,
  output logic [DR_W-1:0]      jdo,
  output logic [IR_W-1:0]      ir_q,
  output logic [2**IR_W-1:0]   take_action,
  output logic [2**IR_W-1:0]   take_no_action,
  output logic                 busy,
  output logic                 overrun,
  output logic [CNT_W-1:0]     cmd_count
);

  localparam int NUM_CH = 2**IR_W;

  logic              udr_evt;
  logic              uir_evt;
  logic [IR_W-1:0]   cmd_ch;
  logic              cmd_act;
  logic              accept;
  logic [NUM_CH-1:0] ch_onehot;

  debug_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_udr_sync (
    .clk   (clk),
    .reset (reset),
    .strobe(vs_udr),
    .evt   (udr_evt)
  );

  debug_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_uir_sync (
    .clk   (clk),
    .reset (reset),
    .strobe(vs_uir),
    .evt   (uir_evt)
  );

  // A pending command is accepted by the ready bit of its own channel only.
  // Without the handshake, every busy cycle counts as accepted, so busy
  // lasts exactly one cycle.
  always_comb begin
    accept = busy & ((READY_EN == 0) | cmd_ready[cmd_ch]);
  end

  // Capture and command-slot state.
  // - udr_evt samples ir_q before this edge's uir_evt update, so a
  //   simultaneous update-IR only affects later commands.
  // - An update-DR while busy is dropped, even if the slot frees at this same
  //   edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q      <= '0;
      jdo       <= '0;
      cmd_ch    <= '0;
      cmd_act   <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      cmd_count <= '0;
    end else begin
      if (uir_evt) begin
        ir_q <= ir_in;
      end

      if (udr_evt && !busy) begin
        jdo     <= sr;
        cmd_ch  <= ir_q;
        cmd_act <= sr[ACT_BIT];
        busy    <= 1'b1;
      end else if (accept) begin
        busy <= 1'b0;
      end

      if (accept) begin
        cmd_count <= cmd_count + CNT_W'(1);
      end

      // When an overrun and a clear arrive together, the set wins.
      if (udr_evt && busy) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  // Decode the pending command onto exactly one bit of one output vector.
  always_comb begin
    ch_onehot      = NUM_CH'(1) << cmd_ch;
    take_action    = (busy &  cmd_act) ? ch_onehot : '0;
    take_no_action = (busy & ~cmd_act) ? ch_onehot : '0;
  end

endmodule

// File: tb/tb_debug_slave_sysclk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_debug_slave_sysclk_ctrl
// Directed bench for debug_slave_sysclk_ctrl.  dut_a uses the handshake
// (READY_EN=1).  dut_b uses single-cycle pulses (READY_EN=0).  Both share
// the same inputs.  Expected commands are queued when a strobe is driven and
// checked against the outputs when the command appears.
// ---------------------------------------------------------------------------
module tb_debug_slave_sysclk_ctrl;
  import debug_slave_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_uir;
  logic        vs_udr;
  logic [3:0]  cmd_ready;
  logic        overrun_clr;

  logic [37:0] a_jdo, b_jdo;
  logic [1:0]  a_ir_q, b_ir_q;
  logic [3:0]  a_ta, a_tna, b_ta, b_tna;
  logic        a_busy, b_busy, a_overrun, b_overrun;
  logic [7:0]  a_count, b_count;

  typedef struct {
    logic [37:0] jdo;
    logic [3:0]  ta;
    logic [3:0]  tna;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  debug_slave_sysclk_ctrl #(.READY_EN(1)) dut_a (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir),
    .vs_udr(vs_udr), .cmd_ready(cmd_ready), .overrun_clr(overrun_clr),
    .jdo(a_jdo), .ir_q(a_ir_q), .take_action(a_ta), .take_no_action(a_tna),
    .busy(a_busy), .overrun(a_overrun), .cmd_count(a_count)
  );

  debug_slave_sysclk_ctrl #(.READY_EN(0)) dut_b (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir),
    .vs_udr(vs_udr), .cmd_ready(cmd_ready), .overrun_clr(overrun_clr),
    .jdo(b_jdo), .ir_q(b_ir_q), .take_action(b_ta), .take_no_action(b_tna),
    .busy(b_busy), .overrun(b_overrun), .cmd_count(b_count)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the command that a strobe carrying val on channel ch should produce.
  task automatic push_expected(input logic [37:0] val, input logic [1:0] ch);
    exp_t e;
    e.jdo = val;
    e.ta  = val[35] ? (4'b0001 << ch) : 4'b0000;
    e.tna = val[35] ? 4'b0000 : (4'b0001 << ch);
    sb_q.push_back(e);
  endtask

  task automatic pop_compare(input string tag, input logic [37:0] jdo_o,
                             input logic [3:0] ta_o, input logic [3:0] tna_o);
    exp_t e;
    checkOutput({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checkOutput({tag, "_jdo"}, 64'(jdo_o), 64'(e.jdo));
      checkOutput({tag, "_take_action"}, 64'(ta_o), 64'(e.ta));
      checkOutput({tag, "_take_no_action"}, 64'(tna_o), 64'(e.tna));
    end
  endtask

  // Raise vs_udr for one cycle with sr = val.  The call returns two edges
  // after the rising edge has been sampled, i.e. when the registered result
  // must be visible.  A new command must not show up one edge early.
  task automatic applyStimulus(input logic [37:0] val, input bit expect_cmd,
                               input logic [1:0] ch);
    sr     = val;
    vs_udr = 1'b1;
    if (expect_cmd) push_expected(val, ch);
    step(1);
    vs_udr = 1'b0;
    step(1);
    if (expect_cmd) checkOutput("latency_not_early", 64'(a_busy), 64'd0);
    step(1);
  endtask

  // Wait a bounded time for dut_a to show a command, then score it.
  task automatic wait_cmd_a(input string tag);
    int cyc = 0;
    while (a_busy !== 1'b1 && cyc < 8) begin
      step(1);
      cyc++;
    end
    checkOutput({tag, "_busy"}, 64'(a_busy), 64'd1);
    pop_compare(tag, a_jdo, a_ta, a_tna);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [37:0] v;

    reset       = 1'b1;
    ir_in       = '0;
    sr          = '0;
    vs_uir      = 1'b0;
    vs_udr      = 1'b0;
    cmd_ready   = '0;
    overrun_clr = 1'b0;
    step(3);

    // Reset state.
    checkOutput("rst_jdo", 64'(a_jdo), 64'd0);
    checkOutput("rst_ir_q", 64'(a_ir_q), 64'd0);
    checkOutput("rst_take_action", 64'(a_ta), 64'd0);
    checkOutput("rst_take_no_action", 64'(a_tna), 64'd0);
    checkOutput("rst_busy", 64'(a_busy), 64'd0);
    checkOutput("rst_overrun", 64'(a_overrun), 64'd0);
    checkOutput("rst_count", 64'(a_count), 64'd0);
    checkOutput("rst_b_busy", 64'(b_busy), 64'd0);
    reset = 1'b0;
    step(1);

    // Action command on channel 2, held until its own ready.
    ir_in  = IR_BREAK;
    vs_uir = 1'b1;
    step(2);
    vs_uir = 1'b0;
    step(3);
    checkOutput("ir_q_break", 64'(a_ir_q), 64'd2);
    applyStimulus(38'h08_0000_1234, 1'b1, 2'd2);
    wait_cmd_a("cmd1");
    for (int i = 0; i < 10; i++) begin
      step(1);
      checkOutput("cmd1_held", 64'(a_ta), 64'b0100);
    end
    cmd_ready = 4'b1011;
    step(3);
    checkOutput("wrong_ready_busy", 64'(a_busy), 64'd1);
    checkOutput("wrong_ready_ta", 64'(a_ta), 64'b0100);
    checkOutput("wrong_ready_count", 64'(a_count), 64'd0);
    cmd_ready = 4'b0100;
    step(1);
    cmd_ready = 4'b0000;
    checkOutput("accept1_busy", 64'(a_busy), 64'd0);
    checkOutput("accept1_count", 64'(a_count), 64'd1);
    checkOutput("accept1_ta", 64'(a_ta), 64'd0);

    // No-action variant on channel 2.
    applyStimulus(38'h00_0000_5678, 1'b1, 2'd2);
    wait_cmd_a("cmd2");

    // Overrun while busy: dropped, sticky flag, clear, then set-wins.
    applyStimulus(38'h0, 1'b0, 2'd2);
    checkOutput("overrun_set", 64'(a_overrun), 64'd1);
    checkOutput("overrun_jdo_kept", 64'(a_jdo), 64'h5678);
    checkOutput("overrun_tna_kept", 64'(a_tna), 64'b0100);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    checkOutput("overrun_cleared", 64'(a_overrun), 64'd0);
    vs_udr = 1'b1;
    step(1);
    vs_udr = 1'b0;
    step(1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    checkOutput("overrun_set_wins", 64'(a_overrun), 64'd1);
    cmd_ready = 4'b0100;
    step(1);
    cmd_ready = 4'b0000;
    checkOutput("accept2_count", 64'(a_count), 64'd2);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    checkOutput("overrun_cleared2", 64'(a_overrun), 64'd0);

    // Simultaneous update-IR and update-DR: the command uses the old ir_q.
    ir_in  = IR_TRACECTRL;
    vs_uir = 1'b1;
    step(1);
    vs_uir = 1'b0;
    step(3);
    checkOutput("ir_q_tracectrl", 64'(a_ir_q), 64'd1);
    ir_in  = IR_TRACEMEM;
    vs_uir = 1'b1;
    applyStimulus(38'h08_0000_00AA, 1'b1, 2'd1);
    vs_uir = 1'b0;
    wait_cmd_a("cmd_simul");
    checkOutput("simul_ir_q_new", 64'(a_ir_q), 64'd3);
    cmd_ready = 4'b0010;
    step(1);
    cmd_ready = 4'b0000;
    checkOutput("accept3_count", 64'(a_count), 64'd3);

    // Pulse mode on dut_b: 300 strobes, channel 0 after reset.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    for (int i = 0; i < 300; i++) begin
      v      = 38'({$urandom(), $urandom()});
      sr     = v;
      vs_udr = 1'b1;
      push_expected(v, 2'd0);
      step(1);
      vs_udr = 1'b0;
      step(2);
      checkOutput("pulse_high", 64'(b_busy), 64'd1);
      pop_compare("pulse", b_jdo, b_ta, b_tna);
      step(1);
      checkOutput("pulse_one_cycle", 64'(b_busy), 64'd0);
      step(4);
    end
    checkOutput("pulse_count_wrap", 64'(b_count), 64'd44);
    checkOutput("pulse_overrun", 64'(b_overrun), 64'd0);

    // Reset while busy, with another strobe inside the synchroniser.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    ir_in  = IR_BREAK;
    vs_uir = 1'b1;
    step(1);
    vs_uir = 1'b0;
    step(3);
    applyStimulus(38'h08_0000_0F0F, 1'b1, 2'd2);
    wait_cmd_a("cmd_pre_reset");
    vs_udr = 1'b1;
    step(1);
    vs_udr = 1'b0;
    reset  = 1'b1;
    step(1);
    checkOutput("midrst_jdo", 64'(a_jdo), 64'd0);
    checkOutput("midrst_ir_q", 64'(a_ir_q), 64'd0);
    checkOutput("midrst_ta", 64'(a_ta), 64'd0);
    checkOutput("midrst_tna", 64'(a_tna), 64'd0);
    checkOutput("midrst_busy", 64'(a_busy), 64'd0);
    checkOutput("midrst_overrun", 64'(a_overrun), 64'd0);
    checkOutput("midrst_count", 64'(a_count), 64'd0);
    reset = 1'b0;
    step(8);
    checkOutput("postrst_busy", 64'(a_busy), 64'd0);
    checkOutput("postrst_ta", 64'(a_ta), 64'd0);
    checkOutput("postrst_count", 64'(a_count), 64'd0);
    checkOutput("postrst_b_busy", 64'(b_busy), 64'd0);
    checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
